// File: rtl/philo_monitor.sv
// ---------------------------------------------------------------------------
// philo_monitor
//
// Passive observer for a ring of dining philosophers. Every clock it samples
// the packed state vector and checks three safety/liveness rules:
//   - no two ring neighbours EATING at the same time (mutex),
//   - every philosopher moves only along legal state transitions,
//   - no philosopher stays HUNGRY for WAIT_BOUND consecutive samples.
// It also counts entries into EATING (meals). All error flags are sticky
// until reset, and err_id_o remembers which philosopher caused the first one.
//
// Ports
//   clk_i         single clock, everything updates on the rising edge
//   reset_i       synchronous, active-high; clears all history
//   st_i          packed states, st_i[2i+1:2i] is philosopher i
//                 (THINKING=0 READING=1 EATING=2 HUNGRY=3)
//   mutex_err_o   sticky: two neighbours EATING together
//   trans_err_o   sticky: illegal transition seen
//   starve_err_o  sticky: a philosopher reached WAIT_BOUND HUNGRY samples
//   err_id_o      philosopher index that raised the first error
//   meal_cnt_o    number of entries into EATING, wraps mod 2^MEAL_W
// ---------------------------------------------------------------------------
module philo_monitor #(
    parameter int N          = 4,
    parameter int WAIT_BOUND = 15,
    parameter int WAIT_W     = 4,
    parameter int MEAL_W     = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [2*N-1:0]       st_i,
    output logic                 mutex_err_o,
    output logic                 trans_err_o,
    output logic                 starve_err_o,
    output logic [$clog2(N)-1:0] err_id_o,
    output logic [MEAL_W-1:0]    meal_cnt_o
);

    localparam int ID_W = $clog2(N);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
    localparam logic [WAIT_W-1:0] BOUND    = WAIT_W'(WAIT_BOUND);

    typedef enum logic [1:0] {
        THINKING = 2'd0,
        READING  = 2'd1,
        EATING   = 2'd2,
        HUNGRY   = 2'd3
    } philState_e;

    logic [2*N-1:0]    prevSt_q;
    logic              prevValid_q;
    logic [WAIT_W-1:0] waitCnt_q [N];
    logic [WAIT_W-1:0] waitCnt_d [N];
    logic              mutexErr_q, mutexErr_d;
    logic              transErr_q, transErr_d;
    logic              starveErr_q, starveErr_d;
    logic [ID_W-1:0]   errId_q, errId_d;
    logic [MEAL_W-1:0] mealCnt_q, mealCnt_d;

    logic [N-1:0]      mutexHit;
    logic [N-1:0]      transHit;
    logic [N-1:0]      starveHit;
    logic [MEAL_W-1:0] mealAdd;

    // Legal moves: the four states form a cycle R->T->H->E->T, and each
    // state may also hold; THINKING may additionally go back to READING.
    function automatic logic isLegal(philState_e p, philState_e c);
        logic ok;
        case (p)
            READING:  ok = (c == READING)  || (c == THINKING);
            THINKING: ok = (c == THINKING) || (c == READING) || (c == HUNGRY);
            EATING:   ok = (c == EATING)   || (c == THINKING);
            HUNGRY:   ok = (c == HUNGRY)   || (c == EATING);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Per-philosopher rule evaluation on the current sample, then merging
    // of the hits into the sticky flags, first-error id and meal count.
    always_comb begin
        philState_e cur;
        philState_e nxt;
        philState_e prv;
        cur       = THINKING;
        nxt       = THINKING;
        prv       = THINKING;
        mutexHit  = '0;
        transHit  = '0;
        starveHit = '0;
        mealAdd   = '0;
        for (int i = 0; i < N; i++) begin
            cur = philState_e'(st_i[2*i +: 2]);
            nxt = philState_e'(st_i[2*((i+1)%N) +: 2]);
            prv = philState_e'(prevSt_q[2*i +: 2]);

            // Pair (i, i+1); the wrap pair (N-1, 0) is reported by N-1.
            mutexHit[i] = (cur == EATING) && (nxt == EATING);
            transHit[i] = prevValid_q && !isLegal(prv, cur);

            if (cur == HUNGRY) begin
                waitCnt_d[i] = (waitCnt_q[i] == WAIT_MAX) ? WAIT_MAX
                                                          : waitCnt_q[i] + WAIT_W'(1);
            end else begin
                waitCnt_d[i] = '0;
            end
            starveHit[i] = (waitCnt_d[i] == BOUND);

            if ((cur == EATING) && (!prevValid_q || (prv != EATING))) begin
                mealAdd = mealAdd + MEAL_W'(1);
            end
        end

        mutexErr_d  = mutexErr_q  | (|mutexHit);
        transErr_d  = transErr_q  | (|transHit);
        starveErr_d = starveErr_q | (|starveHit);
        mealCnt_d   = mealCnt_q + mealAdd;

        // Only the very first error event names a philosopher; scanning
        // downwards lets the lowest index win within the chosen class.
        errId_d = errId_q;
        if (!(mutexErr_q || transErr_q || starveErr_q)) begin
            if (|mutexHit) begin
                for (int i = N-1; i >= 0; i--) begin
                    if (mutexHit[i]) errId_d = ID_W'(i);
                end
            end else if (|transHit) begin
                for (int i = N-1; i >= 0; i--) begin
                    if (transHit[i]) errId_d = ID_W'(i);
                end
            end else if (|starveHit) begin
                for (int i = N-1; i >= 0; i--) begin
                    if (starveHit[i]) errId_d = ID_W'(i);
                end
            end
        end
    end

    // State register. Reset wipes all history, including the previous
    // sample, so the first sample afterwards is never transition-checked.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prevSt_q    <= '0;
            prevValid_q <= 1'b0;
            mutexErr_q  <= 1'b0;
            transErr_q  <= 1'b0;
            starveErr_q <= 1'b0;
            errId_q     <= '0;
            mealCnt_q   <= '0;
            for (int i = 0; i < N; i++) waitCnt_q[i] <= '0;
        end else begin
            prevSt_q    <= st_i;
            prevValid_q <= 1'b1;
            mutexErr_q  <= mutexErr_d;
            transErr_q  <= transErr_d;
            starveErr_q <= starveErr_d;
            errId_q     <= errId_d;
            mealCnt_q   <= mealCnt_d;
            for (int i = 0; i < N; i++) waitCnt_q[i] <= waitCnt_d[i];
        end
    end

    assign mutex_err_o  = mutexErr_q;
    assign trans_err_o  = transErr_q;
    assign starve_err_o = starveErr_q;
    assign err_id_o     = errId_q;
    assign meal_cnt_o   = mealCnt_q;

endmodule
